// File: rtl/dma_cmd_arbiter_if.sv
// dma_cmd_arbiter_if: handshake/bus bundle around the DMA command arbiter.
//   dma_wr_cmd_*  write command channel from data_bridge (valid/ready + data, be, ea, tag)
//   dma_rd_cmd_*  read command channel from data_bridge (valid/ready + be, ea, tag)
//   cmd_*         merged command stream to the command encoder (valid/ready + type, data, be, ea, tag)
// Modports: slave = arbiter side, master = environment side (upstream + encoder).
interface dma_cmd_arbiter_if #(
  parameter int unsigned TAGW = 7
);
  logic            dma_wr_cmd_valid;
  logic            dma_wr_cmd_ready;
  logic [1023:0]   dma_wr_cmd_data;
  logic [127:0]    dma_wr_cmd_be;
  logic [63:0]     dma_wr_cmd_ea;
  logic [TAGW-1:0] dma_wr_cmd_tag;

  logic            dma_rd_cmd_valid;
  logic            dma_rd_cmd_ready;
  logic [127:0]    dma_rd_cmd_be;
  logic [63:0]     dma_rd_cmd_ea;
  logic [TAGW-1:0] dma_rd_cmd_tag;

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_type;
  logic [1023:0]   cmd_data;
  logic [127:0]    cmd_be;
  logic [63:0]     cmd_ea;
  logic [TAGW-1:0] cmd_tag;

  modport slave (
    input  dma_wr_cmd_valid, dma_wr_cmd_data, dma_wr_cmd_be, dma_wr_cmd_ea, dma_wr_cmd_tag,
    output dma_wr_cmd_ready,
    input  dma_rd_cmd_valid, dma_rd_cmd_be, dma_rd_cmd_ea, dma_rd_cmd_tag,
    output dma_rd_cmd_ready,
    output cmd_valid, cmd_type, cmd_data, cmd_be, cmd_ea, cmd_tag,
    input  cmd_ready
  );

  modport master (
    output dma_wr_cmd_valid, dma_wr_cmd_data, dma_wr_cmd_be, dma_wr_cmd_ea, dma_wr_cmd_tag,
    input  dma_wr_cmd_ready,
    output dma_rd_cmd_valid, dma_rd_cmd_be, dma_rd_cmd_ea, dma_rd_cmd_tag,
    input  dma_rd_cmd_ready,
    input  cmd_valid, cmd_type, cmd_data, cmd_be, cmd_ea, cmd_tag,
    output cmd_ready
  );
endinterface

// File: rtl/dma_cmd_arbiter.sv
// dma_cmd_arbiter: merges the write and read DMA command channels into one
// command stream with round-robin arbitration and per-channel credit limits.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     write/read command channels in, merged cmd stream out
//   wr_cred_ret     one write credit returned (1-cycle pulse)
//   rd_cred_ret     one read credit returned (1-cycle pulse)
//   wr_outstanding  write commands in flight
//   rd_outstanding  read commands in flight
//   fir_cred_err    sticky {rd,wr} credit-return underflow
module dma_cmd_arbiter #(
  parameter int unsigned TAGW    = 7,
  parameter int unsigned WR_CRED = 32,
  parameter int unsigned RD_CRED = 32,
  parameter int unsigned CRW     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_cmd_arbiter_if.slave     bus,
  input  logic                 wr_cred_ret,
  input  logic                 rd_cred_ret,
  output logic [CRW-1:0]       wr_outstanding,
  output logic [CRW-1:0]       rd_outstanding,
  output logic [1:0]           fir_cred_err
);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

  gnt_e            last_grant;
  logic            valid_q;
  logic            type_q;
  logic [1023:0]   data_q;
  logic [127:0]    be_q;
  logic [63:0]     ea_q;
  logic [TAGW-1:0] tag_q;
  logic [CRW-1:0]  wr_out_q, rd_out_q;
  logic [CRW-1:0]  wr_out_d, rd_out_d;
  logic [1:0]      err_q;
  logic            wr_uflow, rd_uflow;

  logic load, wr_elig, rd_elig, grant_wr, grant_rd;

  assign load     = !valid_q || bus.cmd_ready;
  assign wr_elig  = bus.dma_wr_cmd_valid && (wr_out_q < CRW'(WR_CRED));
  assign rd_elig  = bus.dma_rd_cmd_valid && (rd_out_q < CRW'(RD_CRED));
  // On a tie the channel not granted last time wins.
  assign grant_wr = load && wr_elig && (!rd_elig || last_grant == GNT_RD);
  assign grant_rd = load && rd_elig && (!wr_elig || last_grant == GNT_WR);

  assign bus.dma_wr_cmd_ready = grant_wr;
  assign bus.dma_rd_cmd_ready = grant_rd;

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_type  = type_q;
  assign bus.cmd_data  = data_q;
  assign bus.cmd_be    = be_q;
  assign bus.cmd_ea    = ea_q;
  assign bus.cmd_tag   = tag_q;

  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;
  assign fir_cred_err   = err_q;

  // Grant and return in the same cycle cancel; a return with nothing in
  // flight leaves the counter at zero and flags an underflow.
  always_comb begin
    wr_out_d = wr_out_q;
    wr_uflow = 1'b0;
    unique case ({grant_wr, wr_cred_ret})
      2'b10:   wr_out_d = wr_out_q + CRW'(1);
      2'b01:   if (wr_out_q == '0) wr_uflow = 1'b1;
               else wr_out_d = wr_out_q - CRW'(1);
      default: wr_out_d = wr_out_q;
    endcase
  end

  always_comb begin
    rd_out_d = rd_out_q;
    rd_uflow = 1'b0;
    unique case ({grant_rd, rd_cred_ret})
      2'b10:   rd_out_d = rd_out_q + CRW'(1);
      2'b01:   if (rd_out_q == '0) rd_uflow = 1'b1;
               else rd_out_d = rd_out_q - CRW'(1);
      default: rd_out_d = rd_out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_RD;
      valid_q    <= 1'b0;
      type_q     <= 1'b0;
      data_q     <= '0;
      be_q       <= '0;
      ea_q       <= '0;
      tag_q      <= '0;
      wr_out_q   <= '0;
      rd_out_q   <= '0;
      err_q      <= '0;
    end else begin
      if (grant_wr) begin
        last_grant <= GNT_WR;
        valid_q    <= 1'b1;
        type_q     <= 1'b0;
        data_q     <= bus.dma_wr_cmd_data;
        be_q       <= bus.dma_wr_cmd_be;
        ea_q       <= bus.dma_wr_cmd_ea;
        tag_q      <= bus.dma_wr_cmd_tag;
      end else if (grant_rd) begin
        last_grant <= GNT_RD;
        valid_q    <= 1'b1;
        type_q     <= 1'b1;
        data_q     <= '0;
        be_q       <= bus.dma_rd_cmd_be;
        ea_q       <= bus.dma_rd_cmd_ea;
        tag_q      <= bus.dma_rd_cmd_tag;
      end else if (bus.cmd_ready) begin
        valid_q    <= 1'b0;
      end
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;
      err_q    <= err_q | {rd_uflow, wr_uflow};
    end
  end

endmodule
